accel_host_ctrl: RTL and testbench

Host-facing control block for the PE-array accelerator. It holds the layer configuration registers and runs the layer launch sequence: it validates the configuration, computes the GLB base addresses over three pipelined cycles, starts the pass controller and waits for its completion. It also arbitrates GLB port ownership between the host/DRAM side and the pass controller. It sits between the host bus and the Controller_pass/GLB pair.

---
 rtl/accel_host_ctrl_if.sv | 23 ++
 rtl/accel_host_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_accel_host_ctrl.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/accel_host_ctrl_if.sv
// GLB request/response port shared by the host, controller and GLB sides.
// The requester is master; the GLB-facing responder is slave.
interface accel_host_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [3:0]        we;
    logic [3:0]        re;
    logic [ADDR_W-1:0] w_addr;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] w_data;
    logic [DATA_W-1:0] r_data;

    modport master (
        output we, re, w_addr, r_addr, w_data,
        input  r_data
    );

    modport slave (
        input  we, re, w_addr, r_addr, w_data,
        output r_data
    );
endinterface

// File: rtl/accel_host_ctrl.sv
// Accelerator host control: config registers, launch FSM with
// pipelined base-address calculation, and GLB port arbitration.
module accel_host_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CFG_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              reg_w_en,
    input  logic [2:0]        reg_wsel,
    input  logic [CFG_W-1:0]  reg_wdata,
    input  logic              reg_r_en,
    input  logic [2:0]        reg_rsel,
    output logic [CFG_W-1:0]  reg_rdata,
    accel_host_ctrl_if.slave  host,
    accel_host_ctrl_if.slave  ctrl,
    accel_host_ctrl_if.master glb,
    output logic              host_stall,
    output logic [CFG_W-1:0]  mapping,
    output logic [CFG_W-1:0]  shape1,
    output logic [CFG_W-1:0]  shape2,
    output logic [CFG_W-1:0]  op_config,
    output logic              bias_ipsum_sel,
    output logic [ADDR_W-1:0] ifmap_base,
    output logic [ADDR_W-1:0] filter_base,
    output logic [ADDR_W-1:0] bias_base,
    output logic [ADDR_W-1:0] opsum_base,
    output logic              ctrl_start,
    output logic              ctrl_abort,
    input  logic              ctrl_done,
    output logic              done,
    output logic              irq
);

    typedef enum logic [1:0] {IDLE, CALC, RUN, DONE} state_t;

    state_t            state;
    logic [1:0]        cnt;
    logic              err;
    logic [ADDR_W-1:0] rows, qr, pt, kk;

    logic busy, host_owner;
    logic wr_cmd, cmd_start, cmd_clear, cmd_abort, cfg_ok;
    logic [ADDR_W-1:0] e, p, q, r, t;
    logic [ADDR_W-1:0] stride, frow, fcol, icol;
    logic [CFG_W-1:0]  status;

    assign busy       = (state == CALC) || (state == RUN);
    assign host_owner = !busy;

    assign wr_cmd    = reg_w_en && (reg_wsel == 3'd5);
    assign cmd_start = wr_cmd && reg_wdata[0];
    assign cmd_clear = wr_cmd && reg_wdata[1];
    assign cmd_abort = wr_cmd && reg_wdata[2];

    assign e      = ADDR_W'(mapping[17:12]);
    assign p      = ADDR_W'(mapping[11:9]);
    assign q      = ADDR_W'(mapping[8:6]);
    assign r      = ADDR_W'(mapping[5:3]);
    assign t      = ADDR_W'(mapping[2:0]);
    assign stride = ADDR_W'(shape1[25:24]);
    assign frow   = ADDR_W'(shape1[23:22]);
    assign fcol   = ADDR_W'(shape1[21:20]);
    assign icol   = ADDR_W'(shape2[7:0]);

    assign cfg_ok = (e != '0) && (stride != '0) && (frow != '0)
                 && (fcol != '0) && (icol != '0);

    assign status = {{(CFG_W-4){1'b0}}, err, done, busy, host_owner};

    assign ifmap_base = '0;

    // Non-owner requests are masked, not queued.
    assign glb.we     = host_owner ? host.we     : ctrl.we;
    assign glb.re     = host_owner ? host.re     : ctrl.re;
    assign glb.w_addr = host_owner ? host.w_addr : ctrl.w_addr;
    assign glb.r_addr = host_owner ? host.r_addr : ctrl.r_addr;
    assign glb.w_data = host_owner ? host.w_data : ctrl.w_data;
    assign host.r_data = host_owner ? glb.r_data : {DATA_W{1'b0}};
    assign ctrl.r_data = host_owner ? {DATA_W{1'b0}} : glb.r_data;
    assign host_stall  = busy && ((|host.we) || (|host.re));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mapping        <= '0;
            shape1         <= '0;
            shape2         <= '0;
            op_config      <= '0;
            bias_ipsum_sel <= 1'b0;
        end else if (reg_w_en && !busy) begin
            case (reg_wsel)
                3'd0:    mapping        <= reg_wdata;
                3'd1:    shape1         <= reg_wdata;
                3'd2:    shape2         <= reg_wdata;
                3'd3:    bias_ipsum_sel <= reg_wdata[0];
                3'd4:    op_config      <= reg_wdata;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_rdata <= '0;
        end else if (reg_r_en) begin
            unique case (1'b1)
                reg_rsel == 3'd0: reg_rdata <= mapping;
                reg_rsel == 3'd1: reg_rdata <= shape1;
                reg_rsel == 3'd2: reg_rdata <= shape2;
                reg_rsel == 3'd3:
                    reg_rdata <= {{(CFG_W-1){1'b0}}, bias_ipsum_sel};
                reg_rsel == 3'd4: reg_rdata <= op_config;
                reg_rsel == 3'd6: reg_rdata <= status;
                default:          reg_rdata <= '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            err         <= 1'b0;
            done        <= 1'b0;
            irq         <= 1'b0;
            ctrl_start  <= 1'b0;
            ctrl_abort  <= 1'b0;
            rows        <= '0;
            qr          <= '0;
            pt          <= '0;
            kk          <= '0;
            filter_base <= '0;
            bias_base   <= '0;
            opsum_base  <= '0;
        end else begin
            irq        <= 1'b0;
            ctrl_start <= 1'b0;
            ctrl_abort <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (cmd_start) begin
                        if (!cfg_ok) begin
                            err <= 1'b1;
                        end else begin
                            err   <= 1'b0;
                            done  <= 1'b0;
                            cnt   <= '0;
                            state <= CALC;
                        end
                    end else if (cmd_clear) begin
                        err   <= 1'b0;
                        done  <= 1'b0;
                        state <= IDLE;
                    end
                end
                CALC: begin
                    cnt <= cnt + 2'd1;
                    case (cnt)
                        2'd0: begin
                            rows <= stride * (e - 1'b1) + frow;
                            qr   <= q * r;
                            pt   <= p * t;
                        end
                        2'd1: begin
                            filter_base <= qr * rows * icol;
                            kk          <= qr * frow * fcol;
                        end
                        default: begin
                            bias_base  <= filter_base + pt * kk;
                            opsum_base <= filter_base + pt * kk
                                        + (pt << 2);
                            ctrl_start <= 1'b1;
                            state      <= RUN;
                        end
                    endcase
                end
                RUN: begin
                    // Completion takes priority over a racing abort.
                    if (ctrl_done) begin
                        done  <= 1'b1;
                        irq   <= 1'b1;
                        state <= DONE;
                    end else if (cmd_abort) begin
                        ctrl_abort <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_accel_host_ctrl.sv
// Directed bench for accel_host_ctrl with a GLB memory model
// and a queue of expected read results.
module tb_accel_host_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        reg_w_en;
    logic [2:0]  reg_wsel;
    logic [31:0] reg_wdata;
    logic        reg_r_en;
    logic [2:0]  reg_rsel;
    logic [31:0] reg_rdata;
    logic        host_stall;
    logic [31:0] mapping, shape1, shape2, op_config;
    logic        bias_ipsum_sel;
    logic [31:0] ifmap_base, filter_base, bias_base, opsum_base;
    logic        ctrl_start, ctrl_abort, ctrl_done, done, irq;

    accel_host_ctrl_if host_if ();
    accel_host_ctrl_if ctrl_if ();
    accel_host_ctrl_if glb_if ();

    accel_host_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .reg_w_en       (reg_w_en),
        .reg_wsel       (reg_wsel),
        .reg_wdata      (reg_wdata),
        .reg_r_en       (reg_r_en),
        .reg_rsel       (reg_rsel),
        .reg_rdata      (reg_rdata),
        .host           (host_if),
        .ctrl           (ctrl_if),
        .glb            (glb_if),
        .host_stall     (host_stall),
        .mapping        (mapping),
        .shape1         (shape1),
        .shape2         (shape2),
        .op_config      (op_config),
        .bias_ipsum_sel (bias_ipsum_sel),
        .ifmap_base     (ifmap_base),
        .filter_base    (filter_base),
        .bias_base      (bias_base),
        .opsum_base     (opsum_base),
        .ctrl_start     (ctrl_start),
        .ctrl_abort     (ctrl_abort),
        .ctrl_done      (ctrl_done),
        .done           (done),
        .irq            (irq)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:15];
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (glb_if.we[b])
                mem[glb_if.w_addr[5:2]][8*b +: 8] <=
                    glb_if.w_data[8*b +: 8];
    end
    assign glb_if.r_data = mem[glb_if.r_addr[5:2]];

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  total = 0;
    int  bad   = 0;
    int  lat;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        sb_t s;
        if (sb_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL sb_empty observed=%h expected=entry", obs);
        end else begin
            s = sb_q.pop_front();
            chk(s.tag, obs, s.exp);
        end
    endtask

    task automatic wr(input logic [2:0] sel, input logic [31:0] d);
        @(negedge clk);
        reg_w_en  = 1'b1;
        reg_wsel  = sel;
        reg_wdata = d;
        @(negedge clk);
        reg_w_en  = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [2:0] sel,
                      input logic [31:0] exp);
        @(negedge clk);
        sb_q.push_back('{tag, exp});
        reg_r_en = 1'b1;
        reg_rsel = sel;
        @(negedge clk);
        reg_r_en = 1'b0;
        pop_chk(reg_rdata);
    endtask

    task automatic host_wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        host_if.we     = 4'hF;
        host_if.w_addr = a;
        host_if.w_data = d;
        @(negedge clk);
        host_if.we     = 4'h0;
    endtask

    task automatic host_rd(input string tag, input logic [31:0] a,
                           input logic [31:0] exp);
        @(negedge clk);
        sb_q.push_back('{tag, exp});
        host_if.re     = 4'hF;
        host_if.r_addr = a;
        #1;
        pop_chk(host_if.r_data);
        host_if.re     = 4'h0;
    endtask

    // Called at the negedge right after the start edge (cycle N+1).
    task automatic wait_start(output int k);
        k = 1;
        while (!ctrl_start && k < 12) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic load_cfg();
        wr(3'd0, 32'h0000_445A);
        wr(3'd1, 32'h01F0_0000);
        wr(3'd2, 32'h0000_0008);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n          = 1'b0;
        reg_w_en       = 1'b0;
        reg_wsel       = '0;
        reg_wdata      = '0;
        reg_r_en       = 1'b0;
        reg_rsel       = '0;
        ctrl_done      = 1'b0;
        host_if.we     = '0;
        host_if.re     = '0;
        host_if.w_addr = '0;
        host_if.r_addr = '0;
        host_if.w_data = '0;
        ctrl_if.we     = '0;
        ctrl_if.re     = '0;
        ctrl_if.w_addr = '0;
        ctrl_if.r_addr = '0;
        ctrl_if.w_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_rdata", reg_rdata, 32'h0);
        chk("rst_start", {31'b0, ctrl_start}, 32'h0);
        chk("rst_done", {31'b0, done}, 32'h0);
        chk("rst_irq", {31'b0, irq}, 32'h0);
        chk("rst_stall", {31'b0, host_stall}, 32'h0);
        chk("rst_fbase", filter_base, 32'h0);
        rst_n = 1'b1;

        rd("status_idle", 3'd6, 32'h1);

        ctrl_done = 1'b1;
        @(negedge clk);
        ctrl_done = 1'b0;
        @(negedge clk);
        chk("done_idle_ign", {30'b0, done, irq}, 32'h0);

        wr(3'd1, 32'h01F0_0000);
        wr(3'd2, 32'h0000_0008);
        wr(3'd5, 32'h1);
        wait_start(lat);
        chk("err_no_start", lat, 32'd12);
        rd("status_err", 3'd6, 32'h9);

        load_cfg();
        wr(3'd3, 32'h1);
        rd("rd_bias_sel", 3'd3, 32'h1);
        host_wr(32'h10, 32'hA5A5_A5A5);
        host_rd("glb_init", 32'h10, 32'hA5A5_A5A5);

        wr(3'd5, 32'h1);
        wait_start(lat);
        chk("start_latency", lat, 32'd4);
        chk("ifmap_base", ifmap_base, 32'd0);
        chk("filter_base", filter_base, 32'd144);
        chk("bias_base", bias_base, 32'd252);
        chk("opsum_base", opsum_base, 32'd268);
        @(negedge clk);
        chk("start_pulse", {31'b0, ctrl_start}, 32'h0);
        rd("status_run", 3'd6, 32'h2);

        wr(3'd0, 32'h0000_1234);
        rd("map_locked", 3'd0, 32'h0000_445A);

        @(negedge clk);
        host_if.we     = 4'hF;
        host_if.w_addr = 32'h10;
        host_if.w_data = 32'hDEAD_BEEF;
        host_if.re     = 4'hF;
        host_if.r_addr = 32'h10;
        ctrl_if.we     = 4'h3;
        ctrl_if.w_addr = 32'h20;
        ctrl_if.w_data = 32'h0000_5A5A;
        #1;
        chk("stall_run", {31'b0, host_stall}, 32'h1);
        chk("glb_we_ctrl", {28'b0, glb_if.we}, 32'h3);
        chk("glb_wa_ctrl", glb_if.w_addr, 32'h20);
        chk("host_rd_zero", host_if.r_data, 32'h0);
        @(negedge clk);
        host_if.we = 4'h0;
        host_if.re = 4'h0;
        ctrl_if.we = 4'h0;

        ctrl_done = 1'b1;
        reg_w_en  = 1'b1;
        reg_wsel  = 3'd5;
        reg_wdata = 32'h4;
        @(negedge clk);
        ctrl_done = 1'b0;
        reg_w_en  = 1'b0;
        chk("irq_on", {31'b0, irq}, 32'h1);
        chk("done_on", {31'b0, done}, 32'h1);
        chk("no_abort", {31'b0, ctrl_abort}, 32'h0);
        @(negedge clk);
        chk("irq_pulse", {31'b0, irq}, 32'h0);
        chk("no_abort2", {31'b0, ctrl_abort}, 32'h0);
        rd("status_done", 3'd6, 32'h5);

        host_rd("glb_unchanged", 32'h10, 32'hA5A5_A5A5);
        host_wr(32'h10, 32'h1122_3344);
        host_rd("glb_host_wr", 32'h10, 32'h1122_3344);

        wr(3'd5, 32'h1);
        chk("done_clr_start", {31'b0, done}, 32'h0);
        wait_start(lat);
        chk("start2_latency", lat, 32'd4);
        wr(3'd5, 32'h4);
        chk("abort_on", {31'b0, ctrl_abort}, 32'h1);
        chk("abort_done0", {31'b0, done}, 32'h0);
        @(negedge clk);
        chk("abort_pulse", {31'b0, ctrl_abort}, 32'h0);
        rd("status_abort", 3'd6, 32'h1);

        wr(3'd5, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("mrst_map", mapping, 32'h0);
        chk("mrst_fbase", filter_base, 32'h0);
        chk("mrst_bbase", bias_base, 32'h0);
        chk("mrst_rdata", reg_rdata, 32'h0);
        chk("mrst_flags",
            {28'b0, ctrl_start, ctrl_abort, done, irq}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        rd("mrst_status", 3'd6, 32'h1);
        load_cfg();
        wr(3'd5, 32'h1);
        wait_start(lat);
        chk("relaunch_lat", lat, 32'd4);
        chk("relaunch_obase", opsum_base, 32'd268);
        ctrl_done = 1'b1;
        @(negedge clk);
        ctrl_done = 1'b0;
        chk("relaunch_irq", {31'b0, irq}, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
